// File: rtl/booth_mult_if.sv
// Start/done handshake and operand/result bus for the sequential Booth multiplier.
interface booth_mult_if #(
  parameter int unsigned WIDTH = 16
);
  logic                      start;
  logic signed [WIDTH-1:0]   multiplicand;
  logic signed [WIDTH-1:0]   multiplier;
  logic                      busy;
  logic                      done;
  logic signed [2*WIDTH-1:0] product;

  modport master (
    output start, multiplicand, multiplier,
    input  busy, done, product
  );

  modport slave (
    input  start, multiplicand, multiplier,
    output busy, done, product
  );
endinterface

// File: rtl/booth_mult.sv
// Sequential radix-2 Booth multiplier: one add/sub plus arithmetic shift per cycle,
// signed 2*WIDTH-bit product after WIDTH iterations.
module booth_mult #(
  parameter int unsigned WIDTH = 16
) (
  input logic         clk,
  input logic         rst_n,
  booth_mult_if.slave bus
);
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(WIDTH - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH:0]     a_q, a_d;
  logic [WIDTH-1:0]   q_q, q_d;
  logic               q1_q, q1_d;
  logic [WIDTH:0]     m_q, m_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic [2*WIDTH-1:0] product_q, product_d;

  logic [WIDTH:0]     a_sum;
  logic [WIDTH:0]     a_shift;
  logic [WIDTH-1:0]   q_shift;

  // Booth recoding on {Q[0], q_1}, then arithmetic shift of {A, Q, q_1}.
  always_comb begin
    unique case ({q_q[0], q1_q})
      2'b01:   a_sum = a_q + m_q;
      2'b10:   a_sum = a_q - m_q;
      default: a_sum = a_q;
    endcase
    a_shift = {a_sum[WIDTH], a_sum[WIDTH:1]};
    q_shift = {a_sum[0], q_q[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    q_d       = q_q;
    q1_d      = q1_q;
    m_d       = m_q;
    cnt_d     = cnt_q;
    product_d = product_q;

    unique case (state_q)
      // The done cycle doubles as an accept slot so back-to-back starts
      // sustain one operation every WIDTH+1 cycles.
      StIdle, StDone: begin
        state_d = StIdle;
        if (bus.start) begin
          a_d     = '0;
          q_d     = bus.multiplier;
          q1_d    = 1'b0;
          m_d     = {bus.multiplicand[WIDTH-1], bus.multiplicand};
          cnt_d   = '0;
          state_d = StRun;
        end
      end
      StRun: begin
        a_d  = a_shift;
        q_d  = q_shift;
        q1_d = q_q[0];
        if (cnt_q == CntLast) begin
          product_d = {a_shift[WIDTH-1:0], q_shift};
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= StIdle;
      a_q       <= '0;
      q_q       <= '0;
      q1_q      <= 1'b0;
      m_q       <= '0;
      cnt_q     <= '0;
      product_q <= '0;
    end else begin
      state_q   <= state_d;
      a_q       <= a_d;
      q_q       <= q_d;
      q1_q      <= q1_d;
      m_q       <= m_d;
      cnt_q     <= cnt_d;
      product_q <= product_d;
    end
  end

  assign bus.busy    = (state_q == StRun);
  assign bus.done    = (state_q == StDone);
  assign bus.product = product_q;
endmodule

// File: tb/tb_booth_mult.sv
// Directed bench for booth_mult: scoreboard of expected products popped on each done pulse.
module tb_booth_mult;
  logic clk = 1'b0;
  logic rst_n;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_pass = 0;
  int   n_done = 0;
  logic [31:0] exp_q[$];
  int          done_q[$];

  booth_mult_if #(.WIDTH(16)) bus ();

  booth_mult #(.WIDTH(16)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    assert (got === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Every done pulse must match the oldest outstanding expected product.
  always @(negedge clk) begin
    if (rst_n === 1'b1 && bus.done === 1'b1) begin
      n_done++;
      done_q.push_back(cyc);
      check("busy_done_excl", 32'(bus.busy), 32'd0);
      check("sb_nonempty", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("product", bus.product, exp_q.pop_front());
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic run_op(input string tag, input logic [15:0] m, input logic [15:0] q,
                        input logic [31:0] exp);
    int acc;
    int bcnt;
    bit seen;
    bus.multiplicand = m;
    bus.multiplier   = q;
    bus.start        = 1'b1;
    exp_q.push_back(exp);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    acc  = cyc;
    bcnt = 0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (bus.done === 1'b1) begin
        seen = 1'b1;
        break;
      end
      if (bus.busy === 1'b1) bcnt++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (seen) begin
      check({tag, "_latency"}, 32'(cyc - acc), 32'd16);
      check({tag, "_busy_cycles"}, 32'(bcnt), 32'd16);
    end
    @(negedge clk);
  endtask

  initial begin
    int  d0;
    int  base;
    bit  seen;
    rst_n            = 1'b0;
    bus.start        = 1'b0;
    bus.multiplicand = '0;
    bus.multiplier   = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_done", 32'(bus.done), 32'd0);
    check("rst_product", bus.product, 32'd0);

    run_op("m3x5", 16'd3, 16'd5, 32'h0000000F);
    run_op("m7x6", 16'hFFF9, 16'd6, 32'hFFFFFFD6);
    run_op("m6x7", 16'd6, 16'hFFF9, 32'hFFFFFFD6);
    run_op("min_sq", 16'h8000, 16'h8000, 32'h40000000);
    run_op("max_min", 16'h7FFF, 16'h8000, 32'hC0008000);
    run_op("zero", 16'd0, 16'h1234, 32'h00000000);

    // Start pulses with other operands while busy must be ignored.
    d0 = n_done;
    bus.multiplicand = 16'd9;
    bus.multiplier   = -16'sd11;
    bus.start        = 1'b1;
    exp_q.push_back(32'hFFFFFF9D);
    @(posedge clk);
    @(negedge clk);
    seen = 1'b0;
    for (int i = 1; i <= 40 && !seen; i++) begin
      bus.start = (i == 3 || i == 10);
      if (i == 3) begin
        bus.multiplicand = 16'd1234;
        bus.multiplier   = 16'd77;
      end else if (i == 10) begin
        bus.multiplicand = 16'hFFFF;
        bus.multiplier   = 16'hFFFF;
      end
      @(negedge clk);
      seen = (bus.done === 1'b1);
    end
    bus.start = 1'b0;
    repeat (20) @(negedge clk);
    check("ignore_one_done", 32'(n_done - d0), 32'd1);
    check("ignore_sb_empty", 32'(exp_q.size()), 32'd0);

    // Asynchronous reset between edges in the middle of RUN.
    bus.multiplicand = 16'd3;
    bus.multiplier   = 16'd5;
    bus.start        = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b0;
    repeat (8) @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_busy", 32'(bus.busy), 32'd0);
    check("midrst_done", 32'(bus.done), 32'd0);
    check("midrst_product", bus.product, 32'd0);
    d0 = n_done;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (25) @(negedge clk);
    check("midrst_no_done", 32'(n_done - d0), 32'd0);
    check("midrst_product_held", bus.product, 32'd0);
    run_op("post_rst", 16'd3, 16'd5, 32'h0000000F);

    // start held high: accepts at E0, E17, E34.
    done_q.delete();
    bus.multiplicand = 16'd2;
    bus.multiplier   = 16'd3;
    bus.start        = 1'b1;
    exp_q.push_back(32'd6);
    exp_q.push_back(32'hFFFFFFEC);
    exp_q.push_back(32'hFFFFD8F0);
    @(posedge clk);
    @(negedge clk);
    base = cyc;
    bus.multiplicand = -16'sd4;
    bus.multiplier   = 16'd5;
    for (int k = 1; k <= 55; k++) begin
      @(negedge clk);
      if (k == 15) check("hold_prev0", bus.product, 32'h0000000F);
      if (k == 17) begin
        bus.multiplicand = 16'd100;
        bus.multiplier   = -16'sd100;
      end
      if (k == 32) check("hold_prev1", bus.product, 32'd6);
      if (k == 34) bus.start = 1'b0;
      if (k == 49) check("hold_prev2", bus.product, 32'hFFFFFFEC);
    end
    check("hold_done_count", 32'(done_q.size()), 32'd3);
    if (done_q.size() == 3) begin
      check("hold_done0", 32'(done_q[0] - base), 32'd16);
      check("hold_done1", 32'(done_q[1] - base), 32'd33);
      check("hold_done2", 32'(done_q[2] - base), 32'd50);
    end
    check("hold_final_product", bus.product, 32'hFFFFD8F0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
